// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multdiv issue controller.
// State encoding, operation codes and the counter-width helper live here.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_ARM_CYCLES  = 2;
    localparam int DEF_WDOG_CYCLES = 40;

    // Bits needed to hold the value n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/md_down_counter.sv
// Loadable down counter that stops at zero and flags it.
// Used for the stale-ready arm mask and, optionally, the WAIT watchdog.
module md_down_counter #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_clrn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_clrn) begin
        if (!i_clrn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/writeback sequencer for the shared iterative multiplier/divider.
// Optional WAIT watchdog is enabled by defining MULTDIV_WATCHDOG_EN.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a result transfers on a rising edge where wb_valid && wb_ready. The producer
// holds its payload stable while valid is high and ready is low.
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter int ARM_CYCLES  = DEF_ARM_CYCLES,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              flush,
    output logic              busy,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    output logic              md_ctrl_mult,
    output logic              md_ctrl_div,
    output logic              md_reset,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_exception,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              timeout,
    output logic [1:0]        dbg_state
);

    localparam int ARM_W = cnt_width(ARM_CYCLES);

    if (ARM_CYCLES < 0 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("multdiv_issue_ctrl: need ARM_CYCLES >= 0 and WDOG_CYCLES >= 1");
    end

    md_state_t         r_state;
    md_state_t         w_next;
    logic              r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_wb_result;
    logic              r_wb_exc;
    logic              r_md_rst;

    logic w_accept;
    logic w_arm_zero;
    logic w_rdy_q;
    logic w_wdog_fire;
    logic w_flush_kill;

    assign w_accept     = req_valid & req_ready;
    assign w_flush_kill = flush & (r_state != ST_IDLE);
    // Ready from the unit only counts once the stale-ready window has expired.
    assign w_rdy_q      = (r_state == ST_WAIT) & md_resultRDY & w_arm_zero;

    md_down_counter #(.W(ARM_W)) u_arm_cnt (
        .i_clock    (clock),
        .i_clrn     (clrn),
        .i_load     (r_state == ST_START),
        .i_load_val (ARM_W'(ARM_CYCLES)),
        .i_dec      (r_state == ST_WAIT),
        .o_zero     (w_arm_zero)
    );

`ifdef MULTDIV_WATCHDOG_EN
    localparam int WDOG_W = cnt_width(WDOG_CYCLES);
    logic w_wdog_zero;
    logic r_timeout;

    // Loaded with N-1 so the N-th WAIT cycle sees zero and gives up.
    md_down_counter #(.W(WDOG_W)) u_wdog_cnt (
        .i_clock    (clock),
        .i_clrn     (clrn),
        .i_load     (r_state == ST_START),
        .i_load_val (WDOG_W'(WDOG_CYCLES - 1)),
        .i_dec      (r_state == ST_WAIT),
        .o_zero     (w_wdog_zero)
    );

    assign w_wdog_fire = (r_state == ST_WAIT) & w_wdog_zero & ~w_rdy_q;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_timeout <= 1'b0;
        end else if (w_wdog_fire && !flush) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdog_fire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT:  if (w_rdy_q || w_wdog_fire) w_next = ST_DONE;
            ST_DONE:  if (wb_ready) w_next = w_accept ? ST_START : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_flush_kill) w_next = ST_IDLE;
    end

    always_comb begin
        req_ready    = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = ~flush;
            ST_DONE: req_ready = wb_ready & ~flush;
            default: req_ready = 1'b0;
        endcase
        md_ctrl_mult = (r_state == ST_START) & (r_op == OP_MULT) & ~flush;
        md_ctrl_div  = (r_state == ST_START) & (r_op == OP_DIV) & ~flush;
        md_reset     = ~clrn | r_md_rst;
        busy         = (r_state != ST_IDLE);
        wb_valid     = (r_state == ST_DONE);
        dbg_state    = r_state;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_op        <= OP_MULT;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_wb_result <= '0;
            r_wb_exc    <= 1'b0;
            r_md_rst    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= req_op;
                r_a   <= req_a;
                r_b   <= req_b;
                r_tag <= req_tag;
            end
            if (w_rdy_q && !flush) begin
                r_wb_result <= md_result;
                r_wb_exc    <= md_exception;
            end else if (w_wdog_fire && !flush) begin
                r_wb_result <= '0;
                r_wb_exc    <= 1'b1;
            end
            r_md_rst <= w_flush_kill | (w_wdog_fire & ~flush);
        end
    end

    assign md_operandA  = r_a;
    assign md_operandB  = r_b;
    assign wb_result    = r_wb_result;
    assign wb_exception = r_wb_exc;
    assign wb_tag       = r_tag;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: vector table, multdiv behavioural model,
// writeback scoreboard and hand-written flush/backpressure/reset sequences.
module tb_multdiv_issue_ctrl;

    localparam int DW  = 32;
    localparam int TW  = 5;
    localparam int ARM = 2;
    localparam int EW  = TW + 1 + DW;

    logic          clock = 1'b0;
    logic          clrn  = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic [TW-1:0] req_tag = '0;
    logic          flush = 1'b0;
    logic          busy;
    logic [DW-1:0] md_operandA;
    logic [DW-1:0] md_operandB;
    logic          md_ctrl_mult;
    logic          md_ctrl_div;
    logic          md_reset;
    logic [DW-1:0] md_result = '0;
    logic          md_exception = 1'b0;
    logic          md_resultRDY = 1'b0;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [DW-1:0] wb_result;
    logic          wb_exception;
    logic [TW-1:0] wb_tag;
    logic          timeout;
    logic [1:0]    dbg_state;

    multdiv_issue_ctrl #(.DATA_W(DW), .TAG_W(TW), .ARM_CYCLES(ARM), .WDOG_CYCLES(40)) dut (
        .clock(clock), .clrn(clrn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush), .busy(busy),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_reset(md_reset),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_exception(wb_exception), .wb_tag(wb_tag), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    int acc_cyc = 0;
    int last_wb_cyc = 0;
    bit wb_valid_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- multdiv behavioural model ----------------
    int  md_delay   = 4;
    bit  stale_mode = 1'b0;
    bit  md_never   = 1'b0;
    int  md_cnt     = 0;
    int  md_stale   = 0;
    bit  md_pending = 1'b0;
    logic [DW-1:0] pend_res = '0;
    logic          pend_exc = 1'b0;
    int  n_mult = 0;
    int  n_div  = 0;
    int  n_mdrst = 0;

    always @(negedge clock) begin
        longint pa, pb, p;
        int qa, qb, lo;
        if (md_reset) begin
            if (clrn) n_mdrst++;
            md_resultRDY = 1'b0;
            md_result    = '0;
            md_exception = 1'b0;
            md_cnt       = 0;
            md_stale     = 0;
            md_pending   = 1'b0;
        end else if (md_ctrl_mult || md_ctrl_div) begin
            qa = $signed(md_operandA);
            qb = $signed(md_operandB);
            if (md_ctrl_mult) begin
                n_mult++;
                pa = qa;
                pb = qb;
                p  = pa * pb;
                lo = int'(p[31:0]);
                pend_res = p[31:0];
                pend_exc = (p != longint'(lo));
            end else begin
                n_div++;
                if (qb == 0) begin
                    pend_res = '0;
                    pend_exc = 1'b1;
                end else begin
                    pend_res = qa / qb;
                    pend_exc = 1'b0;
                end
            end
            md_cnt     = md_delay;
            md_stale   = stale_mode ? ARM + 1 : 0;
            md_pending = !md_never;
            if (!stale_mode) md_resultRDY = 1'b0;
        end else begin
            if (md_stale > 0) begin
                md_stale--;
                if (md_stale == 0) md_resultRDY = 1'b0;
            end
            if (md_cnt > 0) begin
                md_cnt--;
                if (md_cnt == 0 && md_pending) begin
                    md_resultRDY = 1'b1;
                    md_result    = pend_res;
                    md_exception = pend_exc;
                    md_pending   = 1'b0;
                end
            end
        end
    end

    // ---------------- writeback monitor / scoreboard ----------------
    always @(negedge clock) begin
        #1;
        if (clrn) begin
            if (wb_valid && !wb_valid_d) last_wb_cyc = cyc;
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0)
                    check("wb_unexpected", {wb_tag, wb_exception, wb_result}, '0);
                else
                    check("wb_data", {wb_tag, wb_exception, wb_result}, exp_q.pop_front());
            end
        end
        wb_valid_d = clrn ? wb_valid : 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tag);
        bit got = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (req_ready) begin
                got     = 1'b1;
                acc_cyc = cyc + 1;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("issue_accept", 64'(got), 64'd1);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
            @(negedge clock);
            #2;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [TW-1:0] tag;
        int            delay;
        bit            stale;
        logic [DW-1:0] exp_res;
        logic          exp_exc;
        int            exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int m0, d0;
        logic [EW-1:0] held;

        vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 5'd5,  17, 1'b0, 32'hFFFFFFEB, 1'b0, 18};
        vecs[1] = '{1'b1, 32'd100,      32'd0,        5'd9,  6,  1'b0, 32'h00000000, 1'b1, 7};
        vecs[2] = '{1'b0, 32'h00010000, 32'h00010000, 5'd1,  3,  1'b0, 32'h00000000, 1'b1, 4};
        vecs[3] = '{1'b1, 32'd100,      32'd7,        5'd30, 1,  1'b0, 32'h0000000E, 1'b0, 4};
        vecs[4] = '{1'b1, 32'hFFFFFFCE, 32'd5,        5'd31, 8,  1'b0, 32'hFFFFFFF6, 1'b0, 9};
        vecs[5] = '{1'b0, 32'd123,      32'd456,      5'd0,  10, 1'b1, 32'h0000DB18, 1'b0, 11};
        vecs[6] = '{1'b1, 32'hFFFFFFF9, 32'd2,        5'd17, 5,  1'b1, 32'hFFFFFFFD, 1'b0, 6};
        vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 4,  1'b0, 32'h00000001, 1'b0, 5};

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_md_reset", 64'(md_reset), 64'd1);
        check("rst_ctrl",     64'({md_ctrl_mult, md_ctrl_div}), 64'd0);
        check("rst_regs",     64'({md_operandA, wb_result}), 64'd0);
        check("rst_state",    64'({timeout, dbg_state}), 64'd0);
        @(negedge clock);
        clrn = 1'b1;
        #1;
        check("rel_md_reset", 64'(md_reset), 64'd0);

        // Table-driven operations
        for (int v = 0; v < 8; v++) begin
            md_delay   = vecs[v].delay;
            stale_mode = vecs[v].stale;
            md_never   = 1'b0;
            m0 = n_mult;
            d0 = n_div;
            exp_q.push_back({vecs[v].tag, vecs[v].exp_exc, vecs[v].exp_res});
            issue(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag);
            wait_drain(100);
            check($sformatf("latency_v%0d", v), 64'(last_wb_cyc - acc_cyc), 64'(vecs[v].exp_lat));
            check($sformatf("mult_pulses_v%0d", v), 64'(n_mult - m0), 64'(vecs[v].op ? 0 : 1));
            check($sformatf("div_pulses_v%0d", v), 64'(n_div - d0), 64'(vecs[v].op ? 1 : 0));
        end
        stale_mode = 1'b0;

        // Flush in the 5th WAIT cycle: nothing written back, one md_reset cycle
        md_delay = 20;
        m0 = n_mdrst;
        issue(1'b0, 32'd3, 32'd4, 5'd3);
        repeat (5) @(negedge clock);
        flush = 1'b1;
        #1;
        check("flush_in_wait", 64'(dbg_state), 64'd2);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("flush_md_reset_hi", 64'({md_reset, busy, wb_valid}), 64'b100);
        @(negedge clock);
        #1;
        check("flush_md_reset_lo", 64'(md_reset), 64'd0);
        repeat (25) @(negedge clock);
        check("flush_md_reset_count", 64'(n_mdrst - m0), 64'd1);
        md_delay = 4;
        exp_q.push_back({5'd3, 1'b0, 32'd42});
        issue(1'b0, 32'd6, 32'd7, 5'd3);
        wait_drain(60);
        check("post_flush_latency", 64'(last_wb_cyc - acc_cyc), 64'd5);

        // Flush while idle: blocks acceptance, no md_reset
        @(negedge clock);
        flush = 1'b1;
        #1;
        check("idle_flush_ready", 64'({req_ready, busy}), 64'd0);
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("idle_flush_no_rst", 64'(md_reset), 64'd0);

        // Writeback backpressure for 10 cycles, then back-to-back request
        wb_ready = 1'b0;
        held = {5'd7, 1'b0, 32'd100};
        exp_q.push_back(held);
        issue(1'b1, 32'd1000, 32'd10, 5'd7);
        for (int i = 0; i < 40 && !wb_valid; i++) begin
            @(negedge clock);
            #2;
        end
        check("bp_wb_valid_seen", 64'(wb_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #2;
            check($sformatf("bp_hold_%0d", i), 64'({wb_valid, wb_tag, wb_exception, wb_result}),
                  64'({1'b1, held}));
        end
        m0 = n_mult;
        @(negedge clock);
        wb_ready  = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_a     = 32'd5;
        req_b     = 32'd5;
        req_tag   = 5'd2;
        exp_q.push_back({5'd2, 1'b0, 32'd25});
        #1;
        check("bp_req_ready", 64'(req_ready), 64'd1);
        acc_cyc = cyc + 1;
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check("bp_start_next", 64'({md_ctrl_mult, wb_valid}), 64'b10);
        wait_drain(60);
        check("bp_second_latency", 64'(last_wb_cyc - acc_cyc), 64'd5);
        check("bp_second_pulse", 64'(n_mult - m0), 64'd1);

`ifdef MULTDIV_WATCHDOG_EN
        // Unit never answers: watchdog completes the op with an exception
        md_never = 1'b1;
        md_delay = 5;
        m0 = n_mdrst;
        exp_q.push_back({5'd4, 1'b1, 32'd0});
        issue(1'b1, 32'd9, 32'd3, 5'd4);
        wait_drain(120);
        check("wdog_latency", 64'(last_wb_cyc - acc_cyc), 64'd41);
        check("wdog_timeout", 64'(timeout), 64'd1);
        check("wdog_md_reset", 64'(n_mdrst - m0), 64'd1);
        md_never = 1'b0;
`else
        check("timeout_tied", 64'(timeout), 64'd0);
`endif

        // Asynchronous reset in the middle of an operation
        md_delay = 20;
        issue(1'b0, 32'd11, 32'd11, 5'd8);
        repeat (3) @(negedge clock);
        #3;
        clrn = 1'b0;
        #1;
        check("arst_abort", 64'({busy, wb_valid, md_reset}), 64'b001);
        repeat (2) @(negedge clock);
        clrn = 1'b1;
        repeat (30) @(negedge clock);
        #2;
        check("arst_no_wb", 64'({busy, wb_valid, timeout}), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : guard
        #200000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete within the time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "time limit");
    end

endmodule
